// File: rtl/prbs7_frame_gen.sv
// PRBS7 (x^7+x^6+1) 64-bit-per-clock pattern source with programmable bit slip and seed reload.
// Optional single-word error injection is compiled in when ERR_INJECT_EN is defined.
module prbs7_frame_gen #(
    parameter int DW    = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [6:0]       seed,
    input  logic [5:0]       slip,
    input  logic             inj_req,
    input  logic [DW-1:0]    inj_mask,
    output logic             inj_ack,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] word_count,
    output logic [15:0]      inj_count
);

    localparam int AW = $clog2(2 * DW);
    localparam logic [6:0] SEED_ALL_ONES = 7'h7F;

    // ------------------------------------------------------------------
    // Generation stage
    // ------------------------------------------------------------------
    logic [6:0]          lfsr_reg;
    logic [DW-1:0]       w_cur_reg;
    logic [DW-1:0]       w_prev_reg;
    logic                gen_v_reg;
    logic                prev_v_reg;
    logic                enable_d1_reg;

    logic [DW:0][6:0]    chain;
    logic [DW-1:0]       gen_word;
    logic [6:0]          seed_fix;

    assign seed_fix = (seed == 7'd0) ? SEED_ALL_ONES : seed;

    // Unrolled single-bit LFSR steps; bit gi of the word is the gi-th emitted bit.
    assign chain[0] = lfsr_reg;
    for (genvar gi = 0; gi < DW; gi++) begin : g_step
        assign gen_word[gi]  = chain[gi][6] ^ chain[gi][5];
        assign chain[gi + 1] = {chain[gi][5:0], gen_word[gi]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg      <= SEED_ALL_ONES;
            w_cur_reg     <= '0;
            w_prev_reg    <= '0;
            gen_v_reg     <= 1'b0;
            prev_v_reg    <= 1'b0;
            enable_d1_reg <= 1'b0;
        end else if (load) begin
            lfsr_reg      <= seed_fix;
            w_cur_reg     <= '0;
            w_prev_reg    <= '0;
            gen_v_reg     <= 1'b0;
            prev_v_reg    <= 1'b0;
            enable_d1_reg <= enable;
        end else begin
            enable_d1_reg <= enable;
            if (enable) begin
                lfsr_reg   <= chain[DW];
                w_cur_reg  <= gen_word;
                w_prev_reg <= w_cur_reg;
                gen_v_reg  <= 1'b1;
                prev_v_reg <= gen_v_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slip window: dout[i] = {w_cur, w_prev}[DW + i - slip]
    // ------------------------------------------------------------------
    logic [2*DW-1:0] win;
    logic [DW-1:0]   slipped;

    assign win = {w_cur_reg, w_prev_reg};

    for (genvar gi = 0; gi < DW; gi++) begin : g_slip
        localparam logic [AW-1:0] BASE = AW'(DW + gi);
        assign slipped[gi] = win[BASE - AW'(slip)];
    end

    // A nonzero slip reaches into w_prev, so that word must hold real data too.
    // Load flushes the pipeline, so nothing is emitted on the load edge.
    logic out_fire;
    assign out_fire = !load && enable_d1_reg && gen_v_reg && ((slip == 6'd0) || prev_v_reg);

    // ------------------------------------------------------------------
    // Error injection
    // ------------------------------------------------------------------
    logic [DW-1:0] corrupt_mask;

`ifdef ERR_INJECT_EN
    typedef enum logic {
        INJ_IDLE,
        INJ_ARMED
    } inj_state_t;

    inj_state_t    inj_state_reg;
    inj_state_t    inj_state_next;
    logic [DW-1:0] inj_mask_reg;
    logic [DW-1:0] inj_mask_next;
    logic [15:0]   inj_count_reg;
    logic [15:0]   inj_count_next;
    logic          inj_ack_reg;
    logic          inj_hit;

    always_comb begin
        inj_state_next = inj_state_reg;
        inj_mask_next  = inj_mask_reg;
        inj_count_next = inj_count_reg;
        inj_hit        = 1'b0;
        case (inj_state_reg)
            INJ_IDLE: begin
                if (inj_req) begin
                    inj_state_next = INJ_ARMED;
                    inj_mask_next  = inj_mask;
                end
            end
            INJ_ARMED: begin
                if (out_fire) begin
                    inj_hit        = 1'b1;
                    inj_state_next = INJ_IDLE;
                    if (inj_count_reg != 16'hFFFF) begin
                        inj_count_next = inj_count_reg + 16'd1;
                    end
                end
            end
            default: inj_state_next = INJ_IDLE;
        endcase
        // Load drops a pending injection without acknowledging it.
        if (load) begin
            inj_state_next = INJ_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inj_state_reg <= INJ_IDLE;
            inj_mask_reg  <= '0;
            inj_count_reg <= '0;
            inj_ack_reg   <= 1'b0;
        end else begin
            inj_state_reg <= inj_state_next;
            inj_mask_reg  <= inj_mask_next;
            inj_count_reg <= inj_count_next;
            inj_ack_reg   <= inj_hit;
        end
    end

    assign corrupt_mask = inj_hit ? inj_mask_reg : '0;
    assign inj_ack      = inj_ack_reg;
    assign inj_count    = inj_count_reg;
`else
    logic unused_inj_inputs;
    assign unused_inj_inputs = ^{inj_req, inj_mask};
    assign corrupt_mask      = '0;
    assign inj_ack           = 1'b0;
    assign inj_count         = '0;
`endif

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [DW-1:0]    dout_reg;
    logic             dout_valid_reg;
    logic [CNT_W-1:0] word_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            word_count_reg <= '0;
        end else begin
            dout_valid_reg <= out_fire;
            if (out_fire) begin
                dout_reg <= slipped ^ corrupt_mask;
            end
            if (load) begin
                word_count_reg <= '0;
            end else if (out_fire) begin
                word_count_reg <= word_count_reg + CNT_W'(1);
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_prbs7_frame_gen.sv
// Randomized self-checking bench for prbs7_frame_gen against a bit-stream reference model.
// The model follows the ERR_INJECT_EN build option of the design.
module tb_prbs7_frame_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [6:0]  seed;
    logic [5:0]  slip;
    logic        inj_req;
    logic [63:0] inj_mask;
    logic        inj_ack;
    logic [63:0] dout;
    logic        dout_valid;
    logic [31:0] word_count;
    logic [15:0] inj_count;

    prbs7_frame_gen #(.DW(64), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .seed       (seed),
        .slip       (slip),
        .inj_req    (inj_req),
        .inj_mask   (inj_mask),
        .inj_ack    (inj_ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .word_count (word_count),
        .inj_count  (inj_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One PRBS7 period (127 bits) from the seed; stream bit n is tbl[n % 127].
    bit [126:0]  tbl;
    int          n_gen;      // words generated since reset/load
    bit          en_prev;    // enable seen on the previous edge
    bit          m_valid;
    logic [63:0] m_dout;
    logic [31:0] m_wc;
    bit          m_ack;
    logic [15:0] m_ic;
    bit          m_pend;
    logic [63:0] m_mask;

    function automatic bit [126:0] prbs_table(input logic [6:0] sd);
        bit [126:0] t;
        logic [6:0] s;
        bit n;
        s = (sd == 7'd0) ? 7'h7F : sd;
        for (int k = 0; k < 127; k++) begin
            n    = s[6] ^ s[5];
            t[k] = n;
            s    = {s[5:0], n};
        end
        return t;
    endfunction

    // Word k of the stream delayed by sl bits.
    function automatic logic [63:0] model_word(input int k, input int sl);
        logic [63:0] w;
        for (int i = 0; i < 64; i++) w[i] = tbl[(64 * k + i - sl) % 127];
        return w;
    endfunction

    task automatic model_reset();
        tbl     = prbs_table(7'h00);
        n_gen   = 0;
        en_prev = 0;
        m_valid = 0;
        m_dout  = '0;
        m_wc    = '0;
        m_ack   = 0;
        m_ic    = '0;
        m_pend  = 0;
        m_mask  = '0;
    endtask

    task automatic model_edge();
        bit pend_before;
        if (reset) begin
            model_reset();
            return;
        end
        if (load) begin
            tbl     = prbs_table(seed);
            n_gen   = 0;
            m_valid = 0;
            m_wc    = '0;
            m_ack   = 0;
            m_pend  = 0;
            en_prev = enable;
            return;
        end
        pend_before = m_pend;
        m_ack   = 0;
        m_valid = en_prev && (n_gen >= 1) && (slip == 6'd0 || n_gen >= 2);
        if (m_valid) begin
            m_dout = model_word(n_gen - 1, int'(slip));
            m_wc   = m_wc + 32'd1;
`ifdef ERR_INJECT_EN
            if (pend_before) begin
                m_dout = m_dout ^ m_mask;
                m_ack  = 1;
                m_pend = 0;
                if (m_ic != 16'hFFFF) m_ic = m_ic + 16'd1;
            end
`endif
        end
`ifdef ERR_INJECT_EN
        if (!pend_before && inj_req) begin
            m_pend = 1;
            m_mask = inj_mask;
        end
`endif
        en_prev = enable;
        if (enable) n_gen++;
    endtask

    // Advance one clock edge; inputs may be changed on return (2 units after the edge).
    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("dout_valid", {63'd0, dout_valid}, {63'd0, m_valid});
        check("dout", dout, m_dout);
        check("word_count", {32'd0, word_count}, {32'd0, m_wc});
        check("inj_ack", {63'd0, inj_ack}, {63'd0, m_ack});
        check("inj_count", {48'd0, inj_count}, {48'd0, m_ic});
    end

    // ---------------- stimulus ----------------
    initial begin
        bit [126:0] t0;
        reset = 1; enable = 0; load = 0; seed = '0; slip = '0; inj_req = 0; inj_mask = '0;
        model_reset();

        // Pin the model: seed 0 -> 0x7F starts with six zeros then a one.
        t0 = prbs_table(7'h00);
        check("model_first_bits", {57'd0, t0[6:0]}, 64'h40);

        repeat (3) step();
        check("rst_dout", dout, 64'd0);
        check("rst_valid", {63'd0, dout_valid}, 64'd0);
        check("rst_wc", {32'd0, word_count}, 64'd0);
        reset = 0;
        step();

        // Seed 0, slip 0: first word latency and 1000-word run
        load = 1; seed = 7'h00; step(); load = 0;
        enable = 1;
        step();
        check("lat_not_yet", {63'd0, dout_valid}, 64'd0);
        step();
        check("first_valid", {63'd0, dout_valid}, 64'd1);
        check("first_word_lsbs", {57'd0, dout[6:0]}, 64'h40);
        repeat (999) step();
        check("wc_1000", {32'd0, word_count}, 64'd1000);

        // Slip 5: first valid word one cycle later
        load = 1; seed = 7'h00; slip = 6'd5; step(); load = 0;
        step();
        step();
        check("slip_lat_not_yet", {63'd0, dout_valid}, 64'd0);
        step();
        check("slip_first_valid", {63'd0, dout_valid}, 64'd1);
        repeat (50) step();

        // Single injection of bit 0
        slip = 6'd0;
        repeat (5) step();
        inj_req = 1; inj_mask = 64'h1; step(); inj_req = 0;
        step();
`ifdef ERR_INJECT_EN
        check("inj_ack_pulse", {63'd0, inj_ack}, 64'd1);
        check("inj_count_1", {48'd0, inj_count}, 64'd1);
`else
        check("inj_ack_off", {63'd0, inj_ack}, 64'd0);
        check("inj_count_off", {48'd0, inj_count}, 64'd0);
`endif
        step();
        check("inj_ack_drop", {63'd0, inj_ack}, 64'd0);

        // Held request for 10 cycles
        inj_req = 1; inj_mask = {$urandom, $urandom};
        repeat (10) step();
        inj_req = 0;
        repeat (3) step();
`ifdef ERR_INJECT_EN
        check("inj_count_6", {48'd0, inj_count}, 64'd6);
`else
        check("inj_count_off2", {48'd0, inj_count}, 64'd0);
`endif

        // Enable gap 1,0,0,1
        enable = 0; step();
        step();
        check("gap_valid_1", {63'd0, dout_valid}, 64'd0);
        enable = 1; step();
        check("gap_valid_2", {63'd0, dout_valid}, 64'd0);
        step();
        check("gap_resume", {63'd0, dout_valid}, 64'd1);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            enable   = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 99) == 0);
            seed     = 7'($urandom);
            if ($urandom_range(0, 49) == 0)
                slip = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(1, 63));
            inj_req  = ($urandom_range(0, 7) == 0);
            inj_mask = {$urandom, $urandom};
            step();
        end

        // Load together with enable mid-stream
        enable = 1; load = 0; slip = 6'd0; inj_req = 0;
        repeat (10) step();
        load = 1; seed = 7'h2A; step(); load = 0;
        check("load_wc_zero", {32'd0, word_count}, 64'd0);
        check("load_flush", {63'd0, dout_valid}, 64'd0);
        step();
        step();
        check("load_restart_valid", {63'd0, dout_valid}, 64'd1);
        check("load_restart_wc", {32'd0, word_count}, 64'd1);
        repeat (5) step();

        // Asynchronous reset mid-cycle
        reset = 1;
        #1;
        check("async_dout", dout, 64'd0);
        check("async_valid", {63'd0, dout_valid}, 64'd0);
        check("async_wc", {32'd0, word_count}, 64'd0);
        check("async_ack", {63'd0, inj_ack}, 64'd0);
        check("async_ic", {48'd0, inj_count}, 64'd0);
        model_reset();
        step();
        step();
        reset = 0; enable = 1;
        step();
        step();
        check("post_rst_valid", {63'd0, dout_valid}, 64'd1);
        check("post_rst_lsbs", {57'd0, dout[6:0]}, 64'h40);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
